// File: rtl/alu_pkg.sv
// Shared types for the ALU flag register: op encoding, flag bit positions
// and the skid-buffer state encoding.
package alu_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        AND = 2'b10,
        OR  = 2'b11
    } alu_ctrl_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } skid_state_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational N/Z/C/V flag generation from the ALU op, operands, result
// and carry out.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [1:0]   alu_ctrl,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] result,
    input  logic         carry_out,
    output logic [3:0]   flags
);

    alu_ctrl_t op;
    logic      sign_a;
    logic      sign_b;
    logic      sign_r;

    assign op     = alu_ctrl_t'(alu_ctrl);
    assign sign_a = a[N-1];
    assign sign_b = b[N-1];
    assign sign_r = result[N-1];

    // Only the operand sign bits matter for overflow; fold the rest away.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{a[N-2:0], b[N-2:0]};

    always_comb begin
        flags         = 4'b0000;
        flags[FLAG_N] = sign_r;
        flags[FLAG_Z] = (result == '0);
        case (op)
            ADD: begin
                flags[FLAG_C] = carry_out;
                flags[FLAG_V] = (sign_a == sign_b) && (sign_r != sign_a);
            end
            SUB: begin
                flags[FLAG_C] = carry_out;
                flags[FLAG_V] = (sign_a != sign_b) && (sign_r != sign_a);
            end
            default: begin
                flags[FLAG_C] = 1'b0;
                flags[FLAG_V] = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_flags_reg.sv
// Registers ALU results with their flags in a 2-entry skid buffer so the
// upstream ready never depends combinationally on the downstream ready.
module alu_flags_reg
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    input  logic [1:0]   i_alu_ctrl,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [N-1:0] i_result,
    input  logic         i_carry_out,
    input  logic         i_ready,
    output logic         o_ready,
    output logic         o_valid,
    output logic [N-1:0] o_result,
    output logic [3:0]   o_flags
);

    // Handshake: an entry moves on a cycle where valid and ready are both
    // high at the rising edge; valid never waits on ready and, once raised,
    // data stays stable until the transfer completes.

    skid_state_t  state;
    logic [N-1:0] head_result;
    logic [3:0]   head_flags;
    logic [N-1:0] tail_result;
    logic [3:0]   tail_flags;
    logic [3:0]   new_flags;
    logic         push;
    logic         pop;

    alu_flag_gen #(.N(N)) u_flag_gen (
        .alu_ctrl  (i_alu_ctrl),
        .a         (i_a),
        .b         (i_b),
        .result    (i_result),
        .carry_out (i_carry_out),
        .flags     (new_flags)
    );

    assign o_ready  = (state != FULL);
    assign o_valid  = (state != EMPTY);
    assign o_result = head_result;
    assign o_flags  = head_flags;

    assign push = i_valid && o_ready;
    assign pop  = o_valid && i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= EMPTY;
            head_result <= '0;
            head_flags  <= 4'b0000;
            tail_result <= '0;
            tail_flags  <= 4'b0000;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        head_result <= i_result;
                        head_flags  <= new_flags;
                        state       <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_result <= i_result;
                        head_flags  <= new_flags;
                    end else if (push) begin
                        tail_result <= i_result;
                        tail_flags  <= new_flags;
                        state       <= FULL;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    // No push is possible here since o_ready is low.
                    if (pop) begin
                        head_result <= tail_result;
                        head_flags  <= tail_flags;
                        state       <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_flags_reg.sv
// Directed bench for alu_flags_reg: flag vectors, backpressure ordering,
// simultaneous push/pop and reset while full.
module tb_alu_flags_reg;
    import alu_pkg::*;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         i_rst;
    logic         i_valid;
    logic [1:0]   i_alu_ctrl;
    logic [N-1:0] i_a;
    logic [N-1:0] i_b;
    logic [N-1:0] i_result;
    logic         i_carry_out;
    logic         i_ready;
    logic         o_ready;
    logic         o_valid;
    logic [N-1:0] o_result;
    logic [3:0]   o_flags;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [N-1:0] exp_q[$];

    always #5 clk = ~clk;

    alu_flags_reg #(.N(N)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .i_alu_ctrl  (i_alu_ctrl),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_result    (i_result),
        .i_carry_out (i_carry_out),
        .i_ready     (i_ready),
        .o_ready     (o_ready),
        .o_valid     (o_valid),
        .o_result    (o_result),
        .o_flags     (o_flags)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] ctrl, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] r, input logic c);
        i_valid     = 1'b1;
        i_alu_ctrl  = ctrl;
        i_a         = a;
        i_b         = b;
        i_result    = r;
        i_carry_out = c;
    endtask

    // Push one entry into an empty buffer, check it one edge later, drain it.
    task automatic single(input string tag, input logic [1:0] ctrl, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [N-1:0] r, input logic c,
                          input logic [3:0] exp_flags);
        i_ready = 1'b0;
        drive(ctrl, a, b, r, c);
        step();
        i_valid = 1'b0;
        check({tag, "_valid"}, 64'(o_valid), 64'd1);
        check({tag, "_result"}, 64'(o_result), 64'(r));
        check({tag, "_flags"}, 64'(o_flags), 64'(exp_flags));
        i_ready = 1'b1;
        step();
        check({tag, "_drained"}, 64'(o_valid), 64'd0);
        i_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] exp_r;
        logic         accept;

        i_rst       = 1'b1;
        i_valid     = 1'b0;
        i_alu_ctrl  = 2'b00;
        i_a         = '0;
        i_b         = '0;
        i_result    = '0;
        i_carry_out = 1'b0;
        i_ready     = 1'b0;
        repeat (2) step();
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_result", 64'(o_result), 64'd0);
        check("rst_flags", 64'(o_flags), 64'd0);
        i_rst = 1'b0;

        // Flag vectors with hand-computed NZCV.
        single("add_zero", 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 4'b0100);
        single("add_ovf",  2'b00, 8'h7F, 8'h01, 8'h80, 1'b0, 4'b1001);
        single("sub_c",    2'b01, 8'hBD, 8'hA5, 8'h18, 1'b1, 4'b0010);
        single("and_mask", 2'b10, 8'hBD, 8'hA5, 8'hA5, 1'b1, 4'b1000);
        single("or_zero",  2'b11, 8'h00, 8'h00, 8'h00, 1'b1, 4'b0100);
        single("sub_ovf",  2'b01, 8'h80, 8'h01, 8'h7F, 1'b1, 4'b0011);
        single("add_wrap", 2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 4'b0110);

        // Backpressure: three pushes with i_ready low, then drain in order.
        i_ready = 1'b0;
        drive(2'b00, 8'h01, 8'h10, 8'h11, 1'b0);
        exp_q.push_back(8'h11);
        step();
        check("bp_ready_one", 64'(o_ready), 64'd1);
        drive(2'b00, 8'h02, 8'h20, 8'h22, 1'b0);
        exp_q.push_back(8'h22);
        step();
        check("bp_ready_full", 64'(o_ready), 64'd0);
        drive(2'b11, 8'h33, 8'h00, 8'h33, 1'b0);
        exp_q.push_back(8'h33);
        step();
        check("bp_still_full", 64'(o_ready), 64'd0);
        check("bp_head_hold", 64'(o_result), 64'h11);

        i_ready = 1'b1;
        for (int cyc = 0; cyc < 10 && (exp_q.size() > 0 || o_valid); cyc++) begin
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    check("drain_extra", 64'(o_valid), 64'd0);
                end else begin
                    exp_r = exp_q.pop_front();
                    check("drain_order", 64'(o_result), 64'(exp_r));
                end
            end
            accept = i_valid && o_ready;
            step();
            if (accept) i_valid = 1'b0;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
        check("drain_valid", 64'(o_valid), 64'd0);

        // Simultaneous push and pop while holding one entry.
        i_ready = 1'b0;
        drive(2'b00, 8'h40, 8'h04, 8'h44, 1'b0);
        step();
        drive(2'b10, 8'hD5, 8'h55, 8'h55, 1'b1);
        i_ready = 1'b1;
        step();
        i_valid = 1'b0;
        check("pp_valid", 64'(o_valid), 64'd1);
        check("pp_ready", 64'(o_ready), 64'd1);
        check("pp_result", 64'(o_result), 64'h55);
        check("pp_flags", 64'(o_flags), 64'b0000);
        step();
        check("pp_drained", 64'(o_valid), 64'd0);

        // Reset while full under backpressure.
        i_ready = 1'b0;
        drive(2'b00, 8'h01, 8'h01, 8'h02, 1'b0);
        step();
        drive(2'b00, 8'h02, 8'h02, 8'h04, 1'b0);
        step();
        check("rf_full", 64'(o_ready), 64'd0);
        i_rst = 1'b1;
        step();
        check("rf_valid", 64'(o_valid), 64'd0);
        check("rf_ready", 64'(o_ready), 64'd1);
        check("rf_result", 64'(o_result), 64'd0);
        check("rf_flags", 64'(o_flags), 64'd0);

        // First edge after reset release accepts the push.
        i_rst = 1'b0;
        drive(2'b01, 8'h05, 8'h03, 8'h02, 1'b1);
        step();
        i_valid = 1'b0;
        check("post_rst_valid", 64'(o_valid), 64'd1);
        check("post_rst_result", 64'(o_result), 64'h02);
        check("post_rst_flags", 64'(o_flags), 64'b0010);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_flags_reg.md
ALU_FLAGS_REG -- requirements
Module: alu_flags_reg

Interface
REQ-001 Parameter N, default 8: operand and result width in bits; legal range 2..64.
REQ-002 Ports: i_clk, i_rst, i_valid, i_alu_ctrl, i_a, i_b, i_result, i_carry_out, i_ready, o_ready, o_valid, o_result, o_flags.
REQ-003 One clock, i_clk; reset i_rst is synchronous and active-high.
REQ-004 i_clk  in  1  rising-edge clock for all state.
REQ-005 i_rst  in  1  synchronous active-high reset.
REQ-006 i_valid  in  1  upstream ALU stage presents a valid result this cycle.
REQ-007 o_ready  out  1  block can accept an upstream entry this cycle.
REQ-008 i_alu_ctrl  in  2  ALU op applied: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-009 i_a, i_b  in  N each  ALU operands; used only for overflow detection.
REQ-010 i_result  in  N  ALU result.
REQ-011 i_carry_out  in  1  ALU carry; for SUB, 1 means no borrow.
REQ-012 o_valid  out  1  head entry is valid for the downstream consumer.
REQ-013 i_ready  in  1  downstream consumer accepts the head entry this cycle.
REQ-014 o_result  out  N  registered result of the head entry.
REQ-015 o_flags  out  4  registered flags of the head entry: [3] N, [2] Z, [1] C, [0] V.

Function
REQ-016 Push occurs when i_valid && o_ready; pop occurs when o_valid && i_ready.
REQ-017 Storage is a 2-entry skid buffer with states EMPTY, ONE and FULL.
REQ-018 o_ready = (state != FULL), decoded from registered state only; there is no combinational path from i_ready.
REQ-019 o_valid = (state != EMPTY); o_result and o_flags always show the head entry.
REQ-020 Latency: a push into EMPTY appears on o_valid/o_result/o_flags on the next rising edge.
REQ-021 Transitions: EMPTY+push -> ONE. ONE+push,no pop -> FULL (entry goes to tail). ONE+pop,no push -> EMPTY. ONE+push+pop -> ONE (head replaced by new entry). FULL+pop -> ONE (tail moves to head). All other cases hold state.
REQ-022 In FULL, i_valid is ignored; inputs do not alter stored entries.
REQ-023 Stored data is unchanged while o_valid && !i_ready (hold under backpressure).
REQ-024 N flag = i_result[N-1]; Z flag = (i_result == 0).
REQ-025 C flag = i_carry_out for ADD and SUB; C = 0 for AND and OR, whatever i_carry_out is.
REQ-026 V flag for ADD = (a[N-1]==b[N-1]) && (r[N-1]!=a[N-1]); for SUB = (a[N-1]!=b[N-1]) && (r[N-1]!=a[N-1]); for AND and OR, V = 0.
REQ-027 Flags are computed from the inputs at push time and stored with the result; they are never recomputed.
REQ-028 Entry order is strictly FIFO; entries are never dropped or duplicated.

Reset
REQ-029 While i_rst is high at a rising edge: state -> EMPTY, o_valid = 0, o_ready = 1, o_result = 0, o_flags = 4'b0000.
REQ-030 Reset overrides any simultaneous push or pop, including mid-backpressure; all buffered entries are discarded.
REQ-031 The first push is accepted on the first edge where i_rst is low.

Structure
REQ-032 Shared package alu_pkg holds: the alu_ctrl_t enum (ADD, SUB, AND, OR = 00..11), flag bit index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0), and the skid-buffer state enum.
REQ-033 Flag computation is one combinational sub-module, alu_flag_gen, parameterised by N; this block instantiates it once on the input side.
REQ-034 The block is one always_ff for state/storage plus combinational decode; no latches and no asynchronous reset.

Verification
REQ-035 Reset, then ADD a=0x00, b=0x00, r=0x00, c=0 -> after 1 cycle o_valid=1, o_result=0x00, o_flags=0100.
REQ-036 ADD a=0x7F, b=0x01, r=0x80, c=0 -> o_result=0x80, o_flags=1001 (N and V set).
REQ-037 SUB a=0xBD, b=0xA5, r=0x18, c=1 -> o_flags=0010; AND a=0xBD, b=0xA5, r=0xA5, c=1 -> o_flags=1000 (C masked).
REQ-038 With i_ready=0, push 3 entries on consecutive cycles -> o_ready falls after the 2nd; the 3rd is held upstream. Raise i_ready -> entries 1, 2, 3 emerge in order, none lost.
REQ-039 In ONE, push and pop in the same cycle -> state stays ONE and o_result shows the new entry on the next cycle.
REQ-040 Assert i_rst while FULL with i_ready=0 -> next cycle o_valid=0, o_ready=1, o_result=0x00, o_flags=0000.
